gcd_req_sequencer: RTL

//  Upstream feeder and result collector for gcd_top. Takes a word-serial 16-bit operand stream (A,B,C per

---
 rtl/gcd_pkg.sv | 15 +
 rtl/gcd_triple_fifo.sv | 37 +++
 rtl/gcd_req_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared widths, FSM state codes and triple layout for the GCD request sequencer.
package gcd_pkg;
    localparam int GCD_W = 16;
    localparam int TRIPLE_W = 3 * GCD_W;
    localparam logic [GCD_W-1:0] TIMEOUT_RESULT = 16'hFFFF;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;
    typedef struct packed {
        logic [GCD_W-1:0] a;
        logic [GCD_W-1:0] b;
        logic [GCD_W-1:0] c;
    } triple_t;
endpackage

// File: rtl/gcd_triple_fifo.sv
// gcd_triple_fifo: DEPTH-entry FIFO of operand triples; pointers carry one extra wrap bit.
module gcd_triple_fifo
    import gcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic [TRIPLE_W-1:0] i_data,
    output logic [TRIPLE_W-1:0] o_data,
    output logic                o_full,
    output logic                o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic [TRIPLE_W-1:0] r_mem [DEPTH];
    logic w_do_push;
    assign w_do_push = i_push && !o_full;
    assign o_data    = r_mem[r_rd[AW-1:0]];
    assign o_empty   = r_wr == r_rd;
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (i_pop && !o_empty) r_rd <= r_rd + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/gcd_req_sequencer.sv
// gcd_req_sequencer: collects A,B,C word triples, launches gcd_top one request at a time
// and returns results (or a timeout marker) in request order.
module gcd_req_sequencer
    import gcd_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [GCD_W-1:0] in_data,
    output logic             gcd_start,
    output logic [GCD_W-1:0] gcd_A,
    output logic [GCD_W-1:0] gcd_B,
    output logic [GCD_W-1:0] gcd_C,
    input  logic [GCD_W-1:0] gcd_D,
    input  logic             gcd_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [GCD_W-1:0] out_data,
    output logic             out_err,
    output logic             busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic             r_live;
    logic [1:0]       r_wcnt;
    logic [GCD_W-1:0] r_a;
    logic [GCD_W-1:0] r_b;
    logic [1:0]       r_state;
    logic [TW-1:0]    r_tcnt;
    logic [GCD_W-1:0] r_gcd_a;
    logic [GCD_W-1:0] r_gcd_b;
    logic [GCD_W-1:0] r_gcd_c;
    logic [GCD_W-1:0] r_out_data;
    logic             r_out_err;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_push;
    triple_t          w_head;

    // in_ready stays low until the first edge after reset release
    assign in_ready  = r_live && !w_full;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && (r_wcnt == 2'd2);
    assign gcd_start = r_state == S_LAUNCH;
    assign out_valid = r_state == S_HOLD;
    assign gcd_A     = r_gcd_a;
    assign gcd_B     = r_gcd_b;
    assign gcd_C     = r_gcd_c;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign busy      = !w_empty || (r_state != S_IDLE) || (r_wcnt != 2'd0);

    gcd_triple_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (gcd_start),
        .i_data  ({r_a, r_b, in_data}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live <= 1'b0;
            r_wcnt <= 2'd0;
            r_a    <= '0;
            r_b    <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_wcnt <= (r_wcnt == 2'd2) ? 2'd0 : r_wcnt + 2'd1;
                if (r_wcnt == 2'd0) r_a <= in_data;
                if (r_wcnt == 2'd1) r_b <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_tcnt     <= '0;
            r_gcd_a    <= '0;
            r_gcd_b    <= '0;
            r_gcd_c    <= '0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (!w_empty) begin
                    r_state <= S_LAUNCH;
                    r_gcd_a <= w_head.a;
                    r_gcd_b <= w_head.b;
                    r_gcd_c <= w_head.c;
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT;
                    r_tcnt  <= '0;
                end
                // a core result on the final WAIT cycle beats the timeout
                S_WAIT: if (gcd_valid) begin
                    r_state    <= S_HOLD;
                    r_out_data <= gcd_D;
                    r_out_err  <= 1'b0;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    r_state    <= S_HOLD;
                    r_out_data <= TIMEOUT_RESULT;
                    r_out_err  <= 1'b1;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
                S_HOLD: if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
